fifo_rr_arbiter: RTL
====================

# fifo_rr_arbiter

Round-robin arbiter that merges several valid/ready producer streams onto one shared downstream stream, normally the write side of a single shared 1r1w FIFO. Each accepted beat is registered in one output stage and tagged with its source index so the consumer can demultiplex. Provides fair, starvation-free sharing, with optional packet-level grant locking.

## Interface
- NumReq, 4, number of requesters; legal range 2..16
- DataWidth, 8, payload width per beat
- IdWidth, $clog2(NumReq), width of source tag (derived; do not override)

- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- valid_i  input  NumReq  per-requester beat valid
- data_i  input  NumReq x DataWidth  per-requester payload
- last_i  input  NumReq  per-requester end-of-packet marker
- ready_o  output  NumReq  per-requester accept; at most one bit high per cycle
- valid_o  output  1  output register holds a beat
- data_o  output  DataWidth  registered payload
- id_o  output  IdWidth  index of requester that produced data_o
- last_o  output  1  registered last marker
- ready_i  input  1  downstream accept (for a FIFO: its ready_o)

## Operation
- Output stage: single register {data, id, last} with valid flag. Stage can load when `~valid_o | ready_i`.
- Grant: combinational round-robin pick among asserted valid_i, searched from index `prio` upward with wrap (prio, prio+1, …, NumReq-1, 0, …, prio-1).
- ready_o[k] = grant[k] & stage-can-load. Beat accepted on requester k when valid_i[k] & ready_o[k].
- On acceptance: stage loads data_i[k], k, last_i[k]; valid_o=1. Otherwise, if ready_i & valid_o, valid_o=0.
- Priority update on acceptance: prio <= (k+1) mod NumReq (the winner becomes lowest priority). No acceptance: prio unchanged.
- Wrap: k = NumReq-1 gives prio = 0; arithmetic done in IdWidth+1 bits, then reduced mod NumReq, which is correct for non-power-of-two NumReq.
- ready_o never depends on a requester's own valid_i except through the grant pick. ready_o is all zero when no valid_i is high.
- Requester may drop valid_i without a handshake. The arbiter does not hold a grant across cycles except when locked (see Configuration).

## Timing
- Latency: accepted beat visible on valid_o/data_o the next cycle.
- Throughput: one beat per cycle while ready_i=1 (simultaneous drain and load in the same cycle).
- ready_i=0 with valid_o=1: output stage holds data_o/id_o/last_o stable, and all ready_o are 0.
- Reset (asynchronous, immediate): valid_o=0, data_o=0, id_o=0, last_o=0, ready_o=0 while reset is asserted, prio=0, lock cleared. A beat held in the stage is discarded. Reset released mid-packet restarts arbitration from requester 0 unlocked.
- All requesters valid and ready_i constantly high: grant order is 0,1,…,NumReq-1,0,…

## Configuration
- FIFO_ARB_LOCK_EN defined:
  - Two-state FSM: UNLOCKED to LOCKED on acceptance of a beat with last_i=0, recording owner k.
  - While LOCKED, only the owner can be granted. Others see ready_o=0 even if the owner's valid_i=0.
  - LOCKED to UNLOCKED on acceptance of the owner's beat with last_i=1.
  - prio updates only on the packet-ending beat.
  - A single-beat packet (last_i=1) never locks.
- FIFO_ARB_LOCK_EN undefined:
  - No FSM; arbitration and prio update happen on every beat.
  - last_i is carried through to last_o only.

## Structure
- Package fifo_arb_pkg:
  - arb_state_e {ARB_UNLOCKED, ARB_LOCKED}
  - MaxNumReq=16 constant
  - id-width helper function
- Sub-module rr_pick: combinational, parameter NumReq, inputs req and prio, outputs one-hot grant, grant index, and any.
- Top module holds the output register, prio, and the lock FSM.

## Test plan
- Reset: assert reset_i mid-transfer -> valid_o=0 and ready_o=0 at once. After release, all four valid with distinct data 0xA0..0xA3, ready_i=1 -> id_o sequence 0,1,2,3,0 on consecutive cycles.
- Fairness: valid_i=4'b1010 held, ready_i=1 -> id_o alternates 1,3,1,3. Requester 3 drops -> only 1 granted, one per cycle, no idle cycles.
- Backpressure: ready_i=0 for 5 cycles with valid_o=1, data_o=0x5C -> output stable, ready_o=0. ready_i returns -> 0x5C consumed and next beat loaded in the same cycle.
- FIFO coupling: drive into fifo_1r1w (NumEntriesLog2=2) with its consumer stalled -> exactly 4 beats plus 1 staged accepted, then all ready_o=0. No beat lost or duplicated after draining (scoreboard per id).
- Lock (FIFO_ARB_LOCK_EN): requester 2 sends a 3-beat packet while 0 and 1 are valid -> id_o=2,2,2 contiguous, then 0. The owner idles mid-packet -> others stay blocked.
- Lock-disabled build, same stimulus -> beats interleave 2,0,1,2,… and last_o passes through unmodified.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    localparam int MaxNumReq = 16;

    function automatic int id_width(input int num_req);
        return $clog2(num_req);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after prio, wrapping to 0.
module rr_pick #(
    parameter int NumReq  = 4,
    parameter int IdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  req,
    input  logic [IdWidth-1:0] prio,
    output logic [NumReq-1:0]  grant,
    output logic [IdWidth-1:0] grant_idx,
    output logic               any
);

    localparam int SumWidth = IdWidth + 1;
    localparam logic [SumWidth-1:0] NumReqW = SumWidth'(NumReq);

    logic [IdWidth-1:0] idx_s;
    logic               found_s;

    // Scan prio, prio+1, ... with modular wrap; the sum needs one extra bit before reduction
    always_comb begin
        logic [SumWidth-1:0] sum_v;
        logic [IdWidth-1:0]  cand_v;
        logic                hit_v;
        idx_s   = {IdWidth{1'b0}};
        found_s = 1'b0;
        sum_v   = {SumWidth{1'b0}};
        cand_v  = {IdWidth{1'b0}};
        hit_v   = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            sum_v   = {1'b0, prio} + SumWidth'(i);
            cand_v  = (sum_v >= NumReqW) ? IdWidth'(sum_v - NumReqW) : sum_v[IdWidth-1:0];
            hit_v   = req[cand_v] & ~found_s;
            idx_s   = hit_v ? cand_v : idx_s;
            found_s = found_s | hit_v;
        end
    end

    assign grant     = {NumReq{found_s}} & ({{(NumReq-1){1'b0}}, 1'b1} << idx_s);
    assign grant_idx = idx_s;
    assign any       = found_s;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin merge of NumReq valid/ready streams into one registered, source-tagged stage.
// Define FIFO_ARB_LOCK_EN to keep the grant on one requester until its last beat.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8,
    parameter int IdWidth   = id_width(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NumReq-1:0]           valid_i,
    input  logic [NumReq*DataWidth-1:0] data_i,
    input  logic [NumReq-1:0]           last_i,
    output logic [NumReq-1:0]           ready_o,
    output logic                        valid_o,
    output logic [DataWidth-1:0]        data_o,
    output logic [IdWidth-1:0]          id_o,
    output logic                        last_o,
    input  logic                        ready_i
);

    localparam int SumWidth = IdWidth + 1;
    localparam logic [SumWidth-1:0] NumReqW = SumWidth'(NumReq);

    logic [NumReq-1:0]    req_s;
    logic [NumReq-1:0]    grant_s;
    logic [IdWidth-1:0]   grant_idx_s;
    logic                 any_s;
    logic                 can_load_s;
    logic                 accept_s;
    logic                 prio_upd_s;
    logic                 win_last_s;
    logic [SumWidth-1:0]  prio_sum_s;
    logic [IdWidth-1:0]   prio_next_s;
    logic [IdWidth-1:0]   prio_r;
    logic                 valid_r;
    logic [DataWidth-1:0] data_r;
    logic [IdWidth-1:0]   id_r;
    logic                 last_r;

    rr_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_pick (
        .req       (req_s),
        .prio      (prio_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    assign can_load_s = ~valid_r | ready_i;
    assign accept_s   = any_s & can_load_s;
    assign win_last_s = last_i[grant_idx_s];
    // Gated by reset so no requester sees a handshake while the stage is being cleared
    assign ready_o    = grant_s & {NumReq{can_load_s & ~reset_i}};

    // Winner becomes lowest priority; reduction handles non-power-of-two NumReq
    always_comb begin
        prio_sum_s = {1'b0, grant_idx_s} + {{IdWidth{1'b0}}, 1'b1};
        if (prio_sum_s >= NumReqW) begin
            prio_next_s = {IdWidth{1'b0}};
        end else begin
            prio_next_s = prio_sum_s[IdWidth-1:0];
        end
    end

`ifdef FIFO_ARB_LOCK_EN
    arb_state_e         state_r;
    arb_state_e         state_next_s;
    logic [IdWidth-1:0] owner_r;
    logic [NumReq-1:0]  owner_mask_s;

    assign owner_mask_s = {{(NumReq-1){1'b0}}, 1'b1} << owner_r;
    assign req_s        = (state_r == ARB_LOCKED) ? (valid_i & owner_mask_s) : valid_i;

    // Lock state register and packet owner capture
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ARB_UNLOCKED;
            owner_r <= {IdWidth{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s && (state_r == ARB_UNLOCKED) && !win_last_s) begin
                owner_r <= grant_idx_s;
            end
        end
    end

    // Lock transitions; prio advances only when a packet ends
    always_comb begin
        state_next_s = state_r;
        prio_upd_s   = accept_s & win_last_s;
        case (state_r)
            ARB_UNLOCKED: begin
                if (accept_s && !win_last_s) begin
                    state_next_s = ARB_LOCKED;
                end else begin
                    state_next_s = ARB_UNLOCKED;
                end
            end
            ARB_LOCKED: begin
                if (accept_s && win_last_s) begin
                    state_next_s = ARB_UNLOCKED;
                end else begin
                    state_next_s = ARB_LOCKED;
                end
            end
            default: begin
                state_next_s = ARB_UNLOCKED;
                prio_upd_s   = 1'b0;
            end
        endcase
    end
`else
    assign req_s      = valid_i;
    assign prio_upd_s = accept_s;
`endif

    // Output stage and round-robin pointer
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= 1'b0;
            data_r  <= {DataWidth{1'b0}};
            id_r    <= {IdWidth{1'b0}};
            last_r  <= 1'b0;
            prio_r  <= {IdWidth{1'b0}};
        end else begin
            if (accept_s) begin
                valid_r <= 1'b1;
                data_r  <= data_i[grant_idx_s*DataWidth +: DataWidth];
                id_r    <= grant_idx_s;
                last_r  <= win_last_s;
            end else if (ready_i) begin
                valid_r <= 1'b0;
            end
            if (prio_upd_s) begin
                prio_r <= prio_next_s;
            end
        end
    end

    assign valid_o = valid_r;
    assign data_o  = data_r;
    assign id_o    = id_r;
    assign last_o  = last_r;

endmodule
